// File: rtl/clock_pkg.sv
// Shared definitions for the clock front end: set-mode state encoding,
// field indices, and small helpers for field selection and mode stepping.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HOUR = 2;

  // One-hot field select for a state; RUN selects nothing.
  function automatic logic [2:0] field_select(input state_t s);
    logic [2:0] sel;
    sel = 3'b000;
    case (s)
      ST_SET_HOUR: sel[FIELD_HOUR] = 1'b1;
      ST_SET_MIN:  sel[FIELD_MIN]  = 1'b1;
      ST_SET_SEC:  sel[FIELD_SEC]  = 1'b1;
      default:     sel = 3'b000;
    endcase
    return sel;
  endfunction

  function automatic state_t next_mode(input state_t s);
    state_t n;
    case (s)
      ST_RUN:      n = ST_SET_HOUR;
      ST_SET_HOUR: n = ST_SET_MIN;
      ST_SET_MIN:  n = ST_SET_SEC;
      default:     n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key front end: 2-FF synchronizer, stability counter and press event.
// The *_nxt outputs expose the values the registers take at the next edge.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic level_nxt,
  output logic press,
  output logic press_nxt
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYC);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle    = (sync_p1 != level) && (cnt == CNT_DONE);
  assign level_nxt = settle ? sync_p1 : level;
  assign press_nxt = settle && sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      level   <= level_nxt;
      press   <= press_nxt;
      if ((sync_p1 == level) || settle)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Clock front end: 1 Hz prescaler, key debouncing, set-mode FSM and
// per-field manual increment pulses with auto-repeat.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int CLK_DIV          = 50_000_000,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       sec_tick,
  output logic [2:0] is_manual_set,
  output logic [2:0] manual_carry_flag,
  output logic       blink
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLINK_LIM = PW'(CLK_DIV / 2);

  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                 : REPEAT_RATE_CYC;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE_CYC - 1);

  state_t state;
  state_t state_nxt;

  logic mode_level, mode_level_nxt, mode_press, mode_press_nxt;
  logic inc_level, inc_level_nxt, inc_press, inc_press_nxt;
  logic unused_key_bits;

  logic [PW-1:0] presc;
  logic          run_entry;
  logic          set_nxt;

  logic [RW-1:0] rep_cnt;
  logic          rep_act;
  logic          rep_first;
  logic          rep_clear;
  logic          rep_arm;
  logic          rep_fire;
  logic          inc_evt;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_key (
    .clk       (clk),
    .rst       (rst),
    .key       (key_mode),
    .level     (mode_level),
    .level_nxt (mode_level_nxt),
    .press     (mode_press),
    .press_nxt (mode_press_nxt)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_key (
    .clk       (clk),
    .rst       (rst),
    .key       (key_inc),
    .level     (inc_level),
    .level_nxt (inc_level_nxt),
    .press     (inc_press),
    .press_nxt (inc_press_nxt)
  );

  assign unused_key_bits = mode_level ^ mode_level_nxt ^ inc_level ^ inc_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    is_manual_set = field_select(state);
    if (mode_press)
      state_nxt = next_mode(state);
  end

  assign run_entry = (state_nxt == ST_RUN) && (state != ST_RUN);
  assign set_nxt   = (state_nxt != ST_RUN);
  assign blink     = (state != ST_RUN) && (presc < BLINK_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      if (run_entry || (presc == PRESC_MAX))
        presc <= '0;
      else
        presc <= presc + 1'b1;
      // Time stays frozen while any field is being set.
      sec_tick <= (presc == PRESC_MAX) && (state == ST_RUN) && (state_nxt == ST_RUN);
    end
  end

  // Events are evaluated one edge ahead so the carry pulse lands in the same
  // cycle as the registered press event; a coincident mode press wins.
  assign rep_clear = !inc_level_nxt || (state_nxt != state);
  assign rep_arm   = inc_press_nxt && set_nxt && !mode_press_nxt;
  assign rep_fire  = rep_act && !rep_clear &&
                     (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));
  assign inc_evt   = (inc_press_nxt || rep_fire) && set_nxt && !mode_press_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_arm) begin
      rep_act   <= 1'b1;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (!rep_act || rep_clear) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      manual_carry_flag <= 3'b000;
    else
      manual_carry_flag <= inc_evt ? field_select(state_nxt) : 3'b000;
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small timing parameters.
module tb_clock_set_controller;

  logic       clk;
  logic       rst;
  logic       key_mode;
  logic       key_inc;
  logic       sec_tick;
  logic [2:0] is_manual_set;
  logic [2:0] manual_carry_flag;
  logic       blink;

  int checks;
  int errors;
  int cyc;

  clock_set_controller #(
    .CLK_DIV          (10),
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (20),
    .REPEAT_RATE_CYC  (5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .key_mode          (key_mode),
    .key_inc           (key_inc),
    .sec_tick          (sec_tick),
    .is_manual_set     (is_manual_set),
    .manual_carry_flag (manual_carry_flag),
    .blink             (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    repeat (10) step();
    key_mode = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_mode = 1'b0;
    key_inc = 1'b0;
    repeat (3) step();
    checks++;
    if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", sec_tick); end
    checks++;
    if (is_manual_set !== 3'b000) begin errors++; $display("FAIL reset_ims got %b want 000", is_manual_set); end
    checks++;
    if (manual_carry_flag !== 3'b000) begin errors++; $display("FAIL reset_mcf got %b want 000", manual_carry_flag); end
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %b want 0", blink); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_run_ticks();
    for (int k = 1; k <= 50; k++) begin
      step();
      checks++;
      if (sec_tick !== ((k % 10) == 0)) begin
        errors++; $display("FAIL run_tick cyc %0d got %b want %b", k, sec_tick, (k % 10) == 0);
      end
      checks++;
      if ({is_manual_set, manual_carry_flag, blink} !== 7'b0) begin
        errors++; $display("FAIL run_idle cyc %0d got %b want 0", k, {is_manual_set, manual_carry_flag, blink});
      end
    end
  endtask

  task automatic test_mode_cycle();
    logic [2:0] seq [0:4];
    logic [2:0] exp_ims;
    logic       exp_tick;
    logic       exp_blink;
    seq[0] = 3'b000; seq[1] = 3'b100; seq[2] = 3'b010; seq[3] = 3'b001; seq[4] = 3'b000;
    for (int it = 0; it < 4; it++) begin
      for (int k = 1; k <= 20; k++) begin
        key_mode = (k <= 10);
        step();
        exp_ims   = (k < 8) ? seq[it] : seq[it + 1];
        exp_tick  = (it == 3) && (k == 18);
        exp_blink = (exp_ims != 3'b000) && ((cyc % 10) < 5);
        checks++;
        if (is_manual_set !== exp_ims) begin
          errors++; $display("FAIL mode_ims press %0d cyc %0d got %b want %b", it, k, is_manual_set, exp_ims);
        end
        checks++;
        if (sec_tick !== exp_tick) begin
          errors++; $display("FAIL mode_tick press %0d cyc %0d got %b want %b", it, k, sec_tick, exp_tick);
        end
        checks++;
        if (blink !== exp_blink) begin
          errors++; $display("FAIL mode_blink press %0d cyc %0d got %b want %b", it, k, blink, exp_blink);
        end
      end
    end
    key_mode = 1'b0;
  endtask

  task automatic test_auto_repeat();
    logic [2:0] exp_mcf;
    press_mode();
    checks++;
    if (is_manual_set !== 3'b100) begin errors++; $display("FAIL rep_state got %b want 100", is_manual_set); end
    for (int k = 1; k <= 60; k++) begin
      key_inc = (k <= 40);
      step();
      exp_mcf = (k == 7 || k == 27 || k == 32 || k == 37 || k == 42) ? 3'b100 : 3'b000;
      checks++;
      if (manual_carry_flag !== exp_mcf) begin
        errors++; $display("FAIL rep_mcf cyc %0d got %b want %b", k, manual_carry_flag, exp_mcf);
      end
    end
    key_inc = 1'b0;
  endtask

  task automatic test_bounce();
    logic [29:0] pat;
    int pulses;
    pat = 30'b000000000000_111111_001100110011;
    pulses = 0;
    press_mode();
    checks++;
    if (is_manual_set !== 3'b010) begin errors++; $display("FAIL bounce_state got %b want 010", is_manual_set); end
    for (int i = 0; i < 30; i++) begin
      key_inc = pat[i];
      step();
      if (manual_carry_flag == 3'b010) pulses++;
      checks++;
      if (manual_carry_flag !== 3'b000 && manual_carry_flag !== 3'b010) begin
        errors++; $display("FAIL bounce_field cyc %0d got %b want 000/010", i, manual_carry_flag);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bounce_count got %0d want 1", pulses); end
    key_inc = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_ims;
    press_mode();
    checks++;
    if (is_manual_set !== 3'b001) begin errors++; $display("FAIL simul_state got %b want 001", is_manual_set); end
    for (int k = 1; k <= 20; k++) begin
      key_mode = (k <= 10);
      key_inc  = (k <= 10);
      step();
      exp_ims = (k < 8) ? 3'b001 : 3'b000;
      checks++;
      if (is_manual_set !== exp_ims) begin
        errors++; $display("FAIL simul_ims cyc %0d got %b want %b", k, is_manual_set, exp_ims);
      end
      checks++;
      if (manual_carry_flag !== 3'b000) begin
        errors++; $display("FAIL simul_mcf cyc %0d got %b want 000", k, manual_carry_flag);
      end
    end
    for (int k = 1; k <= 20; k++) begin
      key_mode = 1'b0;
      key_inc  = (k <= 10);
      step();
      checks++;
      if ({is_manual_set, manual_carry_flag} !== 6'b0) begin
        errors++; $display("FAIL run_inc cyc %0d got %b want 0", k, {is_manual_set, manual_carry_flag});
      end
    end
    key_inc = 1'b0;
  endtask

  task automatic test_async_reset();
    press_mode();
    press_mode();
    checks++;
    if (is_manual_set !== 3'b010) begin errors++; $display("FAIL arst_state got %b want 010", is_manual_set); end
    for (int k = 1; k <= 27; k++) begin
      key_inc = 1'b1;
      step();
    end
    checks++;
    if (manual_carry_flag !== 3'b010) begin
      errors++; $display("FAIL arst_repeat got %b want 010", manual_carry_flag);
    end
    rst = 1'b1;
    key_inc = 1'b0;
    #1;
    checks++;
    if (is_manual_set !== 3'b000) begin errors++; $display("FAIL arst_ims got %b want 000", is_manual_set); end
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL arst_blink got %b want 0", blink); end
    checks++;
    if (manual_carry_flag !== 3'b000) begin errors++; $display("FAIL arst_mcf got %b want 000", manual_carry_flag); end
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (sec_tick !== (k == 10)) begin
        errors++; $display("FAIL arst_tick cyc %0d got %b want %b", k, sec_tick, k == 10);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_run_ticks();
    test_mode_cycle();
    test_auto_repeat();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
